gemm_accum_fifo: RTL and testbench



---
 rtl/gemm_accum_fifo.sv | 164 ++++++++++++++++
 tb/tb_gemm_accum_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_accum_fifo.sv
// Multi-lane partial-sum FIFO sitting between the systolic array output row
// and the result write-back path. Each entry holds CH signed lanes. Besides
// plain push/pop it supports recirculating accumulation: the head is popped,
// added lane-wise to the incoming row and the sum is pushed to the tail.
// After reset/flush a programmable number of rd_en pulses are swallowed
// before pops take effect (read-priming window).
module gemm_accum_fifo #(
    parameter int CH       = 4,
    parameter int DEPTH    = 8,
    parameter int DWIDTH   = 16,
    parameter int PRIME    = 1,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int SAT      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic                      acc_en,
    input  logic [CH*DWIDTH-1:0]      din,
    input  logic                      rd_en,
    output logic [CH*DWIDTH-1:0]      dout,
    output logic                      dout_valid,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      ovf,
    output logic                      udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (PRIME < 2) ? 1 : $clog2(PRIME + 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
    localparam logic [PW-1:0] PRIME_CNT = PW'(PRIME);

    typedef enum logic {PRIMING, RUN} prime_state_t;

    logic [CH*DWIDTH-1:0] mem [DEPTH];
    logic [AW:0]          wptr;
    logic [AW:0]          rptr;
    prime_state_t         state;
    prime_state_t         state_nx;
    logic [PW-1:0]        prime_cnt;
    logic [PW-1:0]        prime_cnt_nx;

    logic [CH*DWIDTH-1:0] head;
    logic [CH*DWIDTH-1:0] acc_row;
    logic [CH*DWIDTH-1:0] wr_data;
    logic                 acc_req;
    logic                 do_push;
    logic                 do_pop;
    logic                 do_acc;
    logic                 do_write;
    logic                 prime_tick;
    logic                 ovf_set;
    logic                 udf_set;

    // Clamp a (DWIDTH+1)-bit sum to DWIDTH bits; saturate only when enabled.
    function automatic logic signed [DWIDTH-1:0] sat_trunc(input logic signed [DWIDTH:0] s);
        logic signed [DWIDTH-1:0] r;
        r = s[DWIDTH-1:0];
        if (SAT != 0 && (s[DWIDTH] != s[DWIDTH-1])) begin
            r = s[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    // One-bit-wider signed lane add, then saturate or wrap.
    function automatic logic signed [DWIDTH-1:0] lane_add(input logic signed [DWIDTH-1:0] a,
                                                          input logic signed [DWIDTH-1:0] b);
        logic signed [DWIDTH:0] s;
        s = (DWIDTH+1)'(a) + (DWIDTH+1)'(b);
        return sat_trunc(s);
    endfunction

    // Status derived purely from the registered pointers.
    always_comb begin
        count       = wptr - rptr;
        empty       = (count == '0);
        full        = (count == FULL_CNT);
        almost_full = (count >= AF_CNT);
        head        = mem[rptr[AW-1:0]];
        dout        = empty ? '0 : head;
        dout_valid  = !empty && (state == RUN);
    end

    // Lane-wise head + din for the recirculating accumulate path.
    always_comb begin
        acc_row = '0;
        for (int i = 0; i < CH; i++) begin
            acc_row[i*DWIDTH +: DWIDTH] = lane_add(head[i*DWIDTH +: DWIDTH], din[i*DWIDTH +: DWIDTH]);
        end
    end

    // Decode the effective operations from pre-edge state. An accumulate
    // request hides rd_en completely, including from the priming counter.
    always_comb begin
        acc_req    = wr_en && acc_en;
        do_push    = wr_en && !acc_en && !full;
        do_acc     = acc_req && !empty;
        do_pop     = rd_en && !acc_req && (state == RUN) && !empty;
        do_write   = do_push || do_acc;
        wr_data    = acc_en ? acc_row : din;
        prime_tick = rd_en && !acc_req && (state == PRIMING);
        ovf_set    = wr_en && !acc_en && full;
        udf_set    = (acc_req && empty) || (rd_en && !acc_req && (state == RUN) && empty);
    end

    // Priming FSM next-state: count swallowed reads until PRIME is reached.
    always_comb begin
        state_nx     = state;
        prime_cnt_nx = prime_cnt;
        if (state == PRIMING && prime_tick) begin
            prime_cnt_nx = prime_cnt + 1'b1;
            if (prime_cnt + 1'b1 == PRIME_CNT) begin
                state_nx = RUN;
            end
        end
    end

    // Priming FSM state register; reset and flush both restart the window.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= (PRIME == 0) ? RUN : PRIMING;
            prime_cnt <= '0;
        end else begin
            state     <= state_nx;
            prime_cnt <= prime_cnt_nx;
        end
    end

    // Pointers and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
            udf  <= 1'b0;
        end else begin
            if (do_write) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop || do_acc) begin
                rptr <= rptr + 1'b1;
            end
            ovf <= ovf || ovf_set;
            udf <= udf || udf_set;
        end
    end

    // Entry storage: cleared on reset only, flush leaves contents in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!flush && do_write) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_gemm_accum_fifo.sv
// Scoreboard bench for gemm_accum_fifo: two instances (wrap and saturating
// accumulate) share one stimulus stream and are compared against a queue
// based reference model.
module tb_gemm_accum_fifo;

    localparam int CH    = 4;
    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int PRIME = 1;
    localparam int AF    = DEPTH - 1;
    localparam int W     = CH * DW;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst, flush, wr_en, acc_en, rd_en;
    logic [W-1:0] din;
    logic [W-1:0] dout0, dout1;
    logic dv0, dv1, em0, em1, fu0, fu1, af0, af1, ov0, ov1, ud0, ud1;
    logic [CW-1:0] cnt0, cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] exp0[$];
    logic [W-1:0] exp1[$];
    int pc;
    bit run, m_ovf, m_udf;

    gemm_accum_fifo #(.CH(CH), .DEPTH(DEPTH), .DWIDTH(DW), .PRIME(PRIME), .AF_LEVEL(AF), .SAT(0)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .acc_en(acc_en), .din(din),
        .rd_en(rd_en), .dout(dout0), .dout_valid(dv0), .empty(em0), .full(fu0),
        .almost_full(af0), .count(cnt0), .ovf(ov0), .udf(ud0));

    gemm_accum_fifo #(.CH(CH), .DEPTH(DEPTH), .DWIDTH(DW), .PRIME(PRIME), .AF_LEVEL(AF), .SAT(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .acc_en(acc_en), .din(din),
        .rd_en(rd_en), .dout(dout1), .dout_valid(dv1), .empty(em1), .full(fu1),
        .almost_full(af1), .count(cnt1), .ovf(ov1), .udf(ud1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] row4(input int a, input int b, input int c, input int d);
        logic [W-1:0] r;
        int v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < CH; i++) r[i*DW +: DW] = v[i][DW-1:0];
        return r;
    endfunction

    // Reference lane-wise add using plain integer arithmetic.
    function automatic logic [W-1:0] add_row(input logic [W-1:0] h, input logic [W-1:0] d, input bit sat);
        logic [W-1:0] r;
        int hi, lo;
        hi = (1 << (DW - 1)) - 1;
        lo = -(1 << (DW - 1));
        for (int i = 0; i < CH; i++) begin
            int s;
            s = int'($signed(h[i*DW +: DW])) + int'($signed(d[i*DW +: DW]));
            if (sat) begin
                if (s > hi) s = hi;
                else if (s < lo) s = lo;
            end
            r[i*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    // Scoreboard monitor: whenever the DUT hands out an entry, compare it.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && !flush && rd_en && !(wr_en && acc_en)) begin
            if (dv0) begin
                if (exp0.size() == 0) chk("pop0_unexpected", 64'd1, 64'd0);
                else begin e = exp0.pop_front(); chk("pop0_data", dout0, e); end
            end
            if (dv1) begin
                if (exp1.size() == 0) chk("pop1_unexpected", 64'd1, 64'd0);
                else begin e = exp1.pop_front(); chk("pop1_data", dout1, e); end
            end
        end
    end

    // One clock of stimulus: drive, advance the model, then check status.
    task automatic cyc(input bit w, input bit a, input logic [W-1:0] d, input bit r, input bit f, input bit rs);
        int sz;
        logic [W-1:0] h;
        wr_en = w; acc_en = a; din = d; rd_en = r; flush = f; rst = rs;
        if (rs || f) begin
            q0.delete(); q1.delete();
            pc = 0; run = (PRIME == 0); m_ovf = 0; m_udf = 0;
        end else begin
            sz = q0.size();
            if (w && a) begin
                if (sz == 0) m_udf = 1;
                else begin
                    h = q0.pop_front(); q0.push_back(add_row(h, d, 0));
                    h = q1.pop_front(); q1.push_back(add_row(h, d, 1));
                end
            end else begin
                if (r && run && sz == 0) m_udf = 1;
                if (r && run && sz > 0) begin
                    exp0.push_back(q0.pop_front());
                    exp1.push_back(q1.pop_front());
                end else if (r && !run) begin
                    pc++;
                    if (pc == PRIME) run = 1;
                end
                if (w && sz == DEPTH) m_ovf = 1;
                else if (w) begin q0.push_back(d); q1.push_back(d); end
            end
        end
        @(posedge clk);
        #1;
        sz = q0.size();
        chk("count0", 64'(cnt0), 64'(sz));
        chk("count1", 64'(cnt1), 64'(sz));
        chk("empty0", 64'(em0), 64'(sz == 0));
        chk("full0", 64'(fu0), 64'(sz == DEPTH));
        chk("almost_full0", 64'(af0), 64'(sz >= AF));
        chk("dout_valid0", 64'(dv0), 64'(sz > 0 && run));
        chk("dout_valid1", 64'(dv1), 64'(sz > 0 && run));
        chk("ovf0", 64'(ov0), 64'(m_ovf));
        chk("udf0", 64'(ud0), 64'(m_udf));
        chk("ovf1", 64'(ov1), 64'(m_ovf));
        chk("udf1", 64'(ud1), 64'(m_udf));
        chk("dout0", dout0, (sz > 0) ? q0[0] : '0);
        chk("dout1", dout1, (sz > 0) ? q1[0] : '0);
    endtask

    function automatic logic [DW-1:0] rnd_lane();
        case ($urandom % 4)
            0: return 16'h7fff - 16'($urandom % 3);
            1: return 16'h8000 + 16'($urandom % 3);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] one, rd;
        one = row4(1, 1, 1, 1);
        rst = 1; flush = 0; wr_en = 0; acc_en = 0; rd_en = 0; din = '0;

        // reset, including reset with a write pending
        cyc(0, 0, '0, 0, 0, 1);
        cyc(1, 0, row4(9, 9, 9, 9), 1, 0, 1);
        chk("reset_count", 64'(cnt0), 64'd0);

        // priming: first read swallowed, second pops
        cyc(1, 0, row4(1, 2, 3, 4), 0, 0, 0);
        cyc(1, 0, row4(5, 6, 7, 8), 0, 0, 0);
        cyc(0, 0, '0, 1, 0, 0);
        chk("prime_head", dout0, row4(1, 2, 3, 4));
        cyc(0, 0, '0, 1, 0, 0);
        chk("after_pop_head", dout0, row4(5, 6, 7, 8));
        cyc(0, 0, '0, 1, 0, 0);
        cyc(0, 0, '0, 1, 0, 0);      // pop on empty
        chk("udf_direct", 64'(ud0), 64'd1);

        // fill, overflow, push+pop while full
        cyc(0, 0, '0, 0, 1, 0);
        cyc(0, 0, '0, 1, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(1, 0, row4(i, i + 10, -i, 100), 0, 0, 0);
        chk("ovf_direct", 64'(ov0), 64'd1);
        cyc(1, 0, row4(77, 77, 77, 77), 1, 0, 0);
        chk("full_pushpop_count", 64'(cnt0), 64'd7);

        // accumulate boundaries, wrap vs saturate
        cyc(0, 0, '0, 0, 1, 0);
        cyc(0, 0, '0, 1, 0, 0);
        cyc(1, 0, row4(32767, -32768, 5, -5), 0, 0, 0);
        cyc(1, 1, row4(1, -1, 3, -7), 0, 0, 0);
        chk("acc_wrap_lane0", 64'(dout0[15:0]), 64'h8000);
        chk("acc_sat_lane0", 64'(dout1[15:0]), 64'h7fff);
        chk("acc_sat_lane1", 64'(dout1[31:16]), 64'h8000);
        chk("acc_count", 64'(cnt0), 64'd1);

        // recirculate four rows through three passes across pointer wrap
        cyc(0, 0, '0, 0, 1, 0);
        cyc(0, 0, '0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, row4(10 * i, 10 * i + 1, 10 * i + 2, 10 * i + 3), 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(1, 1, one, 0, 0, 0);
        chk("recirc_head", dout0, row4(3, 4, 5, 6));
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, 0, 0);

        // flush mid-stream, priming restarts
        for (int i = 0; i < 5; i++) cyc(1, 0, row4(i, i, i, i), 0, 0, 0);
        cyc(0, 0, '0, 0, 1, 0);
        cyc(1, 0, row4(4, 3, 2, 1), 0, 0, 0);
        // accumulate with rd_en in priming: prime counter must not move
        cyc(1, 1, one, 1, 0, 0);
        cyc(0, 0, '0, 1, 0, 0);
        chk("prime_swallow", 64'(cnt0), 64'd1);
        cyc(1, 0, row4(8, 8, 8, 8), 0, 0, 0);
        cyc(1, 1, one, 1, 0, 0);     // accumulate with rd_en in run
        chk("acc_rd_count", 64'(cnt0), 64'd2);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit w, a, r, f, rs;
            rd = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
            w  = ($urandom % 100) < 55;
            a  = ($urandom % 3) == 0;
            r  = ($urandom % 100) < 50;
            f  = ($urandom % 150) == 0;
            rs = ($urandom % 400) == 0;
            cyc(w, a, rd, r, f, rs);
        end

        cyc(0, 0, '0, 0, 0, 0);
        chk("scoreboard0_drained", 64'(exp0.size()), 64'd0);
        chk("scoreboard1_drained", 64'(exp1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
